// File: rtl/fcpu_pkg.sv
// fcpu_pkg: shared widths, store opcodes, the store queue entry record and a
// small opcode-classification helper for the fcpu memory path.
//   DATA_W / RSV_ID_W / INSTR_W : datapath, ROB tag and opcode widths
//   CDB_W                       : common data bus width, {tag, data}
//   store_queue_entry_t         : one store queue slot (packed)
//   is_store_op()               : true for opcodes the store queue accepts
package fcpu_pkg;

  localparam int DATA_W   = 32;
  localparam int RSV_ID_W = 5;
  localparam int INSTR_W  = 6;
  localparam int CDB_W    = RSV_ID_W + DATA_W;

  localparam logic [INSTR_W-1:0] I_STORE  = 6'd8;
  localparam logic [INSTR_W-1:0] I_STOREB = 6'd9;
  localparam logic [INSTR_W-1:0] I_STORER = 6'd10;
  localparam logic [INSTR_W-1:0] I_OUTPUT = 6'd11;

  typedef struct packed {
    logic                valid;
    logic [RSV_ID_W-1:0] rob_id;
    logic [INSTR_W-1:0]  opcode;
    logic [DATA_W-1:0]   data;
    logic [RSV_ID_W-1:0] data_rob_id;
    logic                data_ready;
    logic [DATA_W-1:0]   address;
    logic                addr_ready;
    logic                committed;
    logic                invalidate;
  } store_queue_entry_t;

  function automatic logic is_store_op(input logic [INSTR_W-1:0] opcode);
    return opcode inside {I_STORE, I_STOREB, I_STORER, I_OUTPUT};
  endfunction

endpackage

// File: rtl/store_queue_age_priority_match.sv
// age_priority_match: picks the youngest matching entry of a circular queue.
//   head, tail : queue pointers (oldest slot, next free slot)
//   match      : per-slot match request
//   valid      : per-slot occupancy
//   winner     : one-hot youngest matching slot (all zero if none)
//   hit        : any slot matched
module age_priority_match
  #(parameter int DEPTH   = 8,
    parameter int DEPTH_W = $clog2(DEPTH))
  (input  logic [DEPTH_W-1:0] head,
   input  logic [DEPTH_W-1:0] tail,
   input  logic [DEPTH-1:0]   match,
   input  logic [DEPTH-1:0]   valid,
   output logic [DEPTH-1:0]   winner,
   output logic               hit);

  // head==tail is ambiguous between empty and full; occupancy resolves it.
  // The scan walks backwards from tail-1 so the first hit is the youngest.
  always_comb begin
    logic [DEPTH_W:0]   span;
    logic [DEPTH_W-1:0] idx;
    winner = '0;
    hit    = 1'b0;
    idx    = '0;
    if (tail == head)
      span = (|valid) ? (DEPTH_W+1)'(DEPTH) : '0;
    else
      span = {1'b0, DEPTH_W'(tail - head)};
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail - DEPTH_W'(i + 1);
      if (!hit && ((DEPTH_W+1)'(i) < span) && match[idx] && valid[idx]) begin
        winner[idx] = 1'b1;
        hit         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_queue.sv
// store_queue: in-order store buffer of the memory functional unit.
//   alloc_*   : program-order store dispatch (alloc_ready back-pressure)
//   addr_*    : resolved effective address from the address pipeline
//   cdb*      : result broadcast, snooped for pending store data
//   commit_*  : ROB commit, optionally dropping the store
//   flush     : discards every uncommitted entry
//   ld_*      : zero-latency load lookup: bypass / forward / stall verdict
//   o_*       : drain port to memory, head entry, held until o_ready
//   count     : occupied entries
module store_queue
  import fcpu_pkg::*;
  #(parameter int DEPTH      = 8,
    parameter int DEPTH_W    = $clog2(DEPTH),
    parameter int FORWARD_EN = 1)
  (input  logic                clk,
   input  logic                nrst,
   input  logic                alloc_valid,
   output logic                alloc_ready,
   input  logic [RSV_ID_W-1:0] alloc_rob_id,
   input  logic [INSTR_W-1:0]  alloc_opcode,
   input  logic [DATA_W-1:0]   alloc_data,
   input  logic [RSV_ID_W-1:0] alloc_data_rob_id,
   input  logic                alloc_data_filled,
   input  logic                addr_valid,
   input  logic [RSV_ID_W-1:0] addr_rob_id,
   input  logic [DATA_W-1:0]   addr_value,
   input  logic [CDB_W-1:0]    cdb,
   input  logic                cdb_valid,
   input  logic                commit_valid,
   input  logic                commit_invalidate,
   input  logic [RSV_ID_W-1:0] commit_id,
   input  logic                flush,
   input  logic                ld_valid,
   input  logic [DATA_W-1:0]   ld_address,
   output logic                ld_bypass,
   output logic                ld_fwd_valid,
   output logic [DATA_W-1:0]   ld_fwd_data,
   output logic                ld_stall,
   output logic                o_valid,
   output logic [INSTR_W-1:0]  o_opcode,
   output logic [RSV_ID_W-1:0] o_rsv_id,
   output logic [DATA_W-1:0]   o_address,
   output logic [DATA_W-1:0]   o_data,
   input  logic                o_ready,
   output logic [DEPTH_W:0]    count);

  localparam bit FWD = (FORWARD_EN != 0);

  store_queue_entry_t entries      [DEPTH];
  store_queue_entry_t entries_next [DEPTH];
  logic [DEPTH_W-1:0] head, tail;
  logic [DEPTH_W:0]   n_committed;
  logic               rst_hold;
  logic               out_block;
  logic               alloc_fire;
  logic               drain_ok, silent_pop, pop;
  logic [RSV_ID_W-1:0] cdb_tag;
  logic [DATA_W-1:0]   cdb_data;

  assign cdb_tag  = cdb[CDB_W-1 -: RSV_ID_W];
  assign cdb_data = cdb[DATA_W-1:0];

  // rst_hold keeps drain and load verdicts quiet for one cycle after reset.
  assign out_block   = !nrst || rst_hold;
  assign alloc_ready = nrst && (count < (DEPTH_W+1)'(DEPTH)) && !flush;
  assign alloc_fire  = alloc_valid && alloc_ready && is_store_op(alloc_opcode);

  // An invalidated committed head leaves without a memory request.
  assign drain_ok   = !out_block && entries[head].valid && entries[head].committed;
  assign silent_pop = drain_ok && entries[head].invalidate;
  assign o_valid    = drain_ok && !entries[head].invalidate &&
                      entries[head].data_ready && entries[head].addr_ready;
  assign pop        = silent_pop || (o_valid && o_ready);
  assign o_opcode   = entries[head].opcode;
  assign o_rsv_id   = entries[head].rob_id;
  assign o_address  = entries[head].address;
  assign o_data     = entries[head].data;

  // Allocation lands first so the CDB/address/commit updates below also see
  // the store written this cycle; flush then clears what is still uncommitted.
  always_comb begin
    entries_next = entries;
    n_committed  = '0;
    if (alloc_fire) begin
      entries_next[tail].valid       = 1'b1;
      entries_next[tail].rob_id      = alloc_rob_id;
      entries_next[tail].opcode      = alloc_opcode;
      entries_next[tail].data        = alloc_data;
      entries_next[tail].data_rob_id = alloc_data_rob_id;
      entries_next[tail].data_ready  = alloc_data_filled;
      entries_next[tail].address     = '0;
      entries_next[tail].addr_ready  = 1'b0;
      entries_next[tail].committed   = 1'b0;
      entries_next[tail].invalidate  = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (entries_next[i].valid) begin
        if (cdb_valid && !entries_next[i].data_ready &&
            entries_next[i].data_rob_id == cdb_tag) begin
          entries_next[i].data       = cdb_data;
          entries_next[i].data_ready = 1'b1;
        end
        if (addr_valid && entries_next[i].rob_id == addr_rob_id) begin
          entries_next[i].address    = addr_value;
          entries_next[i].addr_ready = 1'b1;
        end
        if (commit_valid && entries_next[i].rob_id == commit_id) begin
          entries_next[i].committed  = 1'b1;
          entries_next[i].invalidate = commit_invalidate;
        end
        if (entries_next[i].committed)
          n_committed = n_committed + 1'b1;
      end
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++)
        if (!entries_next[i].committed)
          entries_next[i] = '0;
    end
    if (pop)
      entries_next[head] = '0;
  end

  // Committed entries are contiguous from head, so a flush leaves the tail
  // exactly n_committed slots past the current head.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++)
        entries[i] <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      rst_hold <= 1'b1;
    end else begin
      entries  <= entries_next;
      head     <= head + DEPTH_W'(pop);
      rst_hold <= 1'b0;
      if (flush) begin
        tail  <= head + n_committed[DEPTH_W-1:0];
        count <= n_committed - (DEPTH_W+1)'(pop);
      end else begin
        tail  <= tail + DEPTH_W'(alloc_fire);
        count <= count + (DEPTH_W+1)'(alloc_fire) - (DEPTH_W+1)'(pop);
      end
    end
  end

  logic [DEPTH-1:0]  valid_vec, match_vec, winner;
  logic              hit, any_unresolved, win_ready, ld_active;
  logic [DATA_W-1:0] win_data;

  // Any store with an unknown address could alias the load, so it blocks.
  always_comb begin
    valid_vec      = '0;
    match_vec      = '0;
    any_unresolved = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i]   = entries[i].valid;
      match_vec[i]   = entries[i].valid && entries[i].addr_ready &&
                       entries[i].address == ld_address;
      any_unresolved = any_unresolved || (entries[i].valid && !entries[i].addr_ready);
    end
  end

  age_priority_match #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) u_match (
    .head   (head),
    .tail   (tail),
    .match  (match_vec),
    .valid  (valid_vec),
    .winner (winner),
    .hit    (hit));

  always_comb begin
    win_data  = '0;
    win_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (winner[i]) begin
        win_data  = win_data | entries[i].data;
        win_ready = win_ready | entries[i].data_ready;
      end
    end
  end

  assign ld_active    = ld_valid && !out_block;
  assign ld_fwd_valid = ld_active && !any_unresolved && hit && win_ready && FWD;
  assign ld_stall     = ld_active && (any_unresolved || (hit && !(win_ready && FWD)));
  assign ld_bypass    = ld_active && !any_unresolved && !hit;
  assign ld_fwd_data  = ld_fwd_valid ? win_data : '0;

endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue: self-checking bench for store_queue. Two instances share all
// inputs, one with forwarding enabled and one without. Drains are checked
// against a scoreboard filled at commit time; load verdicts against a table.
module tb_store_queue;
  import fcpu_pkg::*;

  localparam int DEPTH   = 8;
  localparam int DEPTH_W = 3;

  logic clk, nrst;
  logic alloc_valid, alloc_data_filled, addr_valid, cdb_valid;
  logic commit_valid, commit_invalidate, flush, ld_valid, o_ready;
  logic [RSV_ID_W-1:0] alloc_rob_id, alloc_data_rob_id, addr_rob_id, commit_id;
  logic [INSTR_W-1:0]  alloc_opcode;
  logic [DATA_W-1:0]   alloc_data, addr_value, ld_address;
  logic [CDB_W-1:0]    cdb;

  logic alloc_ready, ld_bypass, ld_fwd_valid, ld_stall, o_valid;
  logic [DATA_W-1:0] ld_fwd_data, o_address, o_data;
  logic [INSTR_W-1:0] o_opcode;
  logic [RSV_ID_W-1:0] o_rsv_id;
  logic [DEPTH_W:0] count;

  logic nf_alloc_ready, nf_ld_bypass, nf_ld_fwd_valid, nf_ld_stall, nf_o_valid;
  logic [DATA_W-1:0] nf_ld_fwd_data, nf_o_address, nf_o_data;
  logic [INSTR_W-1:0] nf_o_opcode;
  logic [RSV_ID_W-1:0] nf_o_rsv_id;
  logic [DEPTH_W:0] nf_count;

  store_queue #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W), .FORWARD_EN(1)) dut (
    .clk(clk), .nrst(nrst), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_rob_id(alloc_rob_id), .alloc_opcode(alloc_opcode), .alloc_data(alloc_data),
    .alloc_data_rob_id(alloc_data_rob_id), .alloc_data_filled(alloc_data_filled),
    .addr_valid(addr_valid), .addr_rob_id(addr_rob_id), .addr_value(addr_value),
    .cdb(cdb), .cdb_valid(cdb_valid), .commit_valid(commit_valid),
    .commit_invalidate(commit_invalidate), .commit_id(commit_id), .flush(flush),
    .ld_valid(ld_valid), .ld_address(ld_address), .ld_bypass(ld_bypass),
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data), .ld_stall(ld_stall),
    .o_valid(o_valid), .o_opcode(o_opcode), .o_rsv_id(o_rsv_id),
    .o_address(o_address), .o_data(o_data), .o_ready(o_ready), .count(count));

  store_queue #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W), .FORWARD_EN(0)) dut_nf (
    .clk(clk), .nrst(nrst), .alloc_valid(alloc_valid), .alloc_ready(nf_alloc_ready),
    .alloc_rob_id(alloc_rob_id), .alloc_opcode(alloc_opcode), .alloc_data(alloc_data),
    .alloc_data_rob_id(alloc_data_rob_id), .alloc_data_filled(alloc_data_filled),
    .addr_valid(addr_valid), .addr_rob_id(addr_rob_id), .addr_value(addr_value),
    .cdb(cdb), .cdb_valid(cdb_valid), .commit_valid(commit_valid),
    .commit_invalidate(commit_invalidate), .commit_id(commit_id), .flush(flush),
    .ld_valid(ld_valid), .ld_address(ld_address), .ld_bypass(nf_ld_bypass),
    .ld_fwd_valid(nf_ld_fwd_valid), .ld_fwd_data(nf_ld_fwd_data), .ld_stall(nf_ld_stall),
    .o_valid(nf_o_valid), .o_opcode(nf_o_opcode), .o_rsv_id(nf_o_rsv_id),
    .o_address(nf_o_address), .o_data(nf_o_data), .o_ready(o_ready), .count(nf_count));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct packed {
    logic [RSV_ID_W-1:0] rob;
    logic [INSTR_W-1:0]  op;
    logic [DATA_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
  } drain_t;

  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic        bypass, fwd, stall;
    logic [31:0] data;
    logic        nf_bypass, nf_fwd, nf_stall;
  } ld_vec_t;

  drain_t sb[$];
  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    alloc_valid = 0; alloc_rob_id = '0; alloc_opcode = '0; alloc_data = '0;
    alloc_data_rob_id = '0; alloc_data_filled = 0; addr_valid = 0; addr_rob_id = '0;
    addr_value = '0; cdb = '0; cdb_valid = 0; commit_valid = 0; commit_invalidate = 0;
    commit_id = '0; flush = 0; ld_valid = 0; ld_address = '0;
  endtask

  task automatic allocStore(input logic [RSV_ID_W-1:0] rob, input logic [INSTR_W-1:0] op,
                            input logic [DATA_W-1:0] data, input logic [RSV_ID_W-1:0] tag,
                            input logic filled, input logic has_addr,
                            input logic [DATA_W-1:0] addr);
    alloc_valid = 1; alloc_rob_id = rob; alloc_opcode = op; alloc_data = data;
    alloc_data_rob_id = tag; alloc_data_filled = filled;
    addr_valid = has_addr; addr_rob_id = rob; addr_value = addr;
    tick();
    alloc_valid = 0; alloc_data_filled = 0; addr_valid = 0;
  endtask

  task automatic commitStore(input logic [RSV_ID_W-1:0] rob, input logic inv,
                             input logic push, input logic [INSTR_W-1:0] op,
                             input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] data);
    commit_valid = 1; commit_id = rob; commit_invalidate = inv;
    if (push) sb.push_back('{rob: rob, op: op, addr: addr, data: data});
    tick();
    commit_valid = 0; commit_invalidate = 0;
  endtask

  // Waits (bounded) for a drain request with o_ready high and compares it
  // against the oldest scoreboard entry; the accepting edge is consumed.
  task automatic expectDrain(input string name);
    drain_t exp;
    bit found = 0;
    o_ready = 1;
    for (int c = 0; c < 20 && !found; c++) begin
      #1;
      if (o_valid) begin
        found = 1;
        if (sb.size() == 0) begin
          checkOutput({name, "_unexpected"}, 1, 0);
        end else begin
          exp = sb.pop_front();
          checkOutput({name, "_rob"},  64'(o_rsv_id),  64'(exp.rob));
          checkOutput({name, "_op"},   64'(o_opcode),  64'(exp.op));
          checkOutput({name, "_addr"}, 64'(o_address), 64'(exp.addr));
          checkOutput({name, "_data"}, 64'(o_data),    64'(exp.data));
        end
      end
      @(posedge clk);
      #1;
    end
    if (!found) checkOutput({name, "_timeout"}, 0, 1);
  endtask

  task automatic applyStimulus(input ld_vec_t v);
    ld_valid = v.valid;
    ld_address = v.addr;
    #1;
  endtask

  ld_vec_t ld_table [5];

  initial begin
    ld_table[0] = '{1, 32'h40,  0, 1, 0, 32'h22, 0, 0, 1};
    ld_table[1] = '{1, 32'h80,  0, 0, 1, 32'h0,  0, 0, 1};
    ld_table[2] = '{1, 32'h44,  1, 0, 0, 32'h0,  1, 0, 0};
    ld_table[3] = '{1, 32'h100, 1, 0, 0, 32'h0,  1, 0, 0};
    ld_table[4] = '{0, 32'h40,  0, 0, 0, 32'h0,  0, 0, 0};

    clearInputs();
    o_ready = 0;
    nrst = 0;
    ld_valid = 1; ld_address = 32'h40;
    #1;
    checkOutput("rst_alloc_ready", 64'(alloc_ready), 0);
    tick(); tick();
    checkOutput("rst_count", 64'(count), 0);
    checkOutput("rst_o_valid", 64'(o_valid), 0);
    checkOutput("rst_ld_bypass", 64'(ld_bypass), 0);
    nrst = 1;
    #1;
    checkOutput("post_rst_ld_bypass", 64'(ld_bypass), 0);
    checkOutput("post_rst_alloc_ready", 64'(alloc_ready), 1);
    tick();
    checkOutput("ld_empty_bypass", 64'(ld_bypass), 1);
    ld_valid = 0;

    $display("[TB] basic store drain");
    allocStore(5'd3, I_STORE, 32'hA5, 5'd0, 1, 1, 32'h100);
    commitStore(5'd3, 0, 1, I_STORE, 32'h100, 32'hA5);
    #1;
    checkOutput("basic_o_valid", 64'(o_valid), 1);
    tick();
    checkOutput("basic_hold_o_valid", 64'(o_valid), 1);
    checkOutput("basic_hold_addr", 64'(o_address), 64'h100);
    expectDrain("basic");
    o_ready = 0;
    checkOutput("basic_count", 64'(count), 0);

    $display("[TB] load forwarding table");
    allocStore(5'd1, I_STORE,  32'h11, 5'd0, 1, 1, 32'h40);
    allocStore(5'd2, I_STOREB, 32'h22, 5'd0, 1, 1, 32'h40);
    allocStore(5'd4, I_STORE,  32'h0,  5'd9, 0, 1, 32'h80);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(ld_table[i]);
      checkOutput($sformatf("ld%0d_bypass", i), 64'(ld_bypass), 64'(ld_table[i].bypass));
      checkOutput($sformatf("ld%0d_fwd", i), 64'(ld_fwd_valid), 64'(ld_table[i].fwd));
      checkOutput($sformatf("ld%0d_stall", i), 64'(ld_stall), 64'(ld_table[i].stall));
      if (ld_table[i].fwd)
        checkOutput($sformatf("ld%0d_data", i), 64'(ld_fwd_data), 64'(ld_table[i].data));
      checkOutput($sformatf("nf_ld%0d_bypass", i), 64'(nf_ld_bypass), 64'(ld_table[i].nf_bypass));
      checkOutput($sformatf("nf_ld%0d_fwd", i), 64'(nf_ld_fwd_valid), 64'(ld_table[i].nf_fwd));
      checkOutput($sformatf("nf_ld%0d_stall", i), 64'(nf_ld_stall), 64'(ld_table[i].nf_stall));
    end
    ld_valid = 0;
    allocStore(5'd6, I_STORE, 32'h66, 5'd0, 1, 0, 32'h0);
    ld_valid = 1; ld_address = 32'h44;
    #1;
    checkOutput("unresolved_stall", 64'(ld_stall), 1);
    checkOutput("unresolved_bypass", 64'(ld_bypass), 0);
    ld_valid = 0;
    addr_valid = 1; addr_rob_id = 5'd6; addr_value = 32'h40;
    tick();
    addr_valid = 0;
    ld_valid = 1; ld_address = 32'h40;
    #1;
    checkOutput("youngest_fwd", 64'(ld_fwd_valid), 1);
    checkOutput("youngest_data", 64'(ld_fwd_data), 64'h66);
    ld_valid = 0;
    flush = 1;
    tick();
    flush = 0;
    checkOutput("flush_all_count", 64'(count), 0);
    checkOutput("nf_flush_all_count", 64'(nf_count), 0);

    $display("[TB] cdb capture vs load");
    allocStore(5'd7, I_STORE, 32'h0, 5'd5, 0, 1, 32'h200);
    cdb_valid = 1; cdb = {5'd5, 32'h77};
    ld_valid = 1; ld_address = 32'h200;
    #1;
    checkOutput("cdb_same_cycle_stall", 64'(ld_stall), 1);
    tick();
    cdb_valid = 0;
    #1;
    checkOutput("cdb_next_fwd", 64'(ld_fwd_valid), 1);
    checkOutput("cdb_next_data", 64'(ld_fwd_data), 64'h77);
    ld_valid = 0;
    flush = 1;
    tick();
    flush = 0;

    $display("[TB] full queue and pointer wrap");
    for (int i = 0; i < DEPTH; i++)
      allocStore(RSV_ID_W'(10 + i), I_STORE, 32'h1000 + i, 5'd0, 1, 1, 32'h300 + 4 * i);
    checkOutput("full_count", 64'(count), 64'(DEPTH));
    checkOutput("full_alloc_ready", 64'(alloc_ready), 0);
    allocStore(5'd19, I_STORE, 32'hDEAD, 5'd0, 1, 1, 32'h900);
    checkOutput("full_refused_count", 64'(count), 64'(DEPTH));
    commitStore(5'd10, 0, 1, I_STORE, 32'h300, 32'h1000);
    o_ready = 1;
    #1;
    checkOutput("full_no_bypass_ready", 64'(alloc_ready), 0);
    expectDrain("full_first");
    o_ready = 0;
    checkOutput("after_pop_alloc_ready", 64'(alloc_ready), 1);
    checkOutput("after_pop_count", 64'(count), 64'(DEPTH - 1));
    allocStore(5'd18, I_OUTPUT, 32'h1008, 5'd0, 1, 1, 32'h320);
    for (int i = 1; i < DEPTH; i++)
      commitStore(RSV_ID_W'(10 + i), 0, 1, I_STORE, 32'h300 + 4 * i, 32'h1000 + i);
    commitStore(5'd18, 0, 1, I_OUTPUT, 32'h320, 32'h1008);
    for (int i = 0; i < DEPTH; i++)
      expectDrain($sformatf("wrap%0d", i));
    o_ready = 0;
    checkOutput("wrap_count", 64'(count), 0);

    $display("[TB] flush with committed entries");
    for (int i = 0; i < 5; i++)
      allocStore(RSV_ID_W'(20 + i), I_STORER, 32'h2000 + i, 5'd0, 1, 1, 32'h400 + 4 * i);
    commitStore(5'd20, 0, 1, I_STORER, 32'h400, 32'h2000);
    commitStore(5'd21, 0, 1, I_STORER, 32'h404, 32'h2001);
    flush = 1; commit_valid = 1; commit_id = 5'd22;
    sb.push_back('{rob: 5'd22, op: I_STORER, addr: 32'h408, data: 32'h2002});
    #1;
    checkOutput("flush_alloc_ready", 64'(alloc_ready), 0);
    tick();
    flush = 0; commit_valid = 0;
    checkOutput("flush_keep_count", 64'(count), 3);
    allocStore(5'd25, I_STORE, 32'h55, 5'd0, 1, 1, 32'h500);
    commitStore(5'd25, 1, 0, I_STORE, 32'h500, 32'h55);
    expectDrain("flush_d0");
    expectDrain("flush_d1");
    expectDrain("flush_d2");
    o_ready = 0;
    checkOutput("inval_o_valid", 64'(o_valid), 0);
    checkOutput("inval_count_before", 64'(count), 1);
    tick();
    checkOutput("inval_count_after", 64'(count), 0);

    $display("[TB] reset during drain");
    allocStore(5'd30, I_STORE, 32'h99, 5'd0, 1, 1, 32'h600);
    commitStore(5'd30, 0, 0, I_STORE, 32'h600, 32'h99);
    #1;
    checkOutput("mid_o_valid", 64'(o_valid), 1);
    nrst = 0;
    #1;
    checkOutput("mid_rst_o_valid", 64'(o_valid), 0);
    checkOutput("mid_rst_alloc_ready", 64'(alloc_ready), 0);
    tick();
    checkOutput("mid_rst_count", 64'(count), 0);
    nrst = 1;
    ld_valid = 1; ld_address = 32'h600;
    #1;
    checkOutput("mid_post_o_valid", 64'(o_valid), 0);
    checkOutput("mid_post_ld_bypass", 64'(ld_bypass), 0);
    tick();
    checkOutput("mid_after_ld_bypass", 64'(ld_bypass), 1);
    ld_valid = 0;

    checkOutput("scoreboard_empty", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
